// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer: drain states, entry layout,
// default geometry and the power-of-two depth check.
package sb_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;

    typedef enum logic [0:0] {
        SB_IDLE  = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_e;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

    function automatic bit sb_is_pow2(input int unsigned n);
        return (n >= 32'd2) && ((n & (n - 32'd1)) == 32'd0);
    endfunction

    localparam bit SB_DEPTH_OK = sb_is_pow2(SB_DEPTH);

endpackage

// File: rtl/sb_match.sv
// Youngest-match search over the pending entries of the store buffer.
// Entries are scanned oldest to youngest so the last hit is the youngest one.
module sb_match
    import sb_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  sb_entry_t              entries_i [DEPTH],
    input  logic [PTR_W-1:0]       head_i,
    input  logic [CNT_W-1:0]       count_i,
    input  logic [SB_AW-1:0]       addr_i,
    output logic                   hit_o,
    output logic [PTR_W-1:0]       hit_idx_o
);

    logic [PTR_W-1:0] pos_s;
    logic             match_s;

    // Walk from head over count entries; later matches override earlier ones.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = {PTR_W{1'b0}};
        pos_s     = {PTR_W{1'b0}};
        match_s   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pos_s     = head_i + PTR_W'(i);
            match_s   = (CNT_W'(i) < count_i) && (entries_i[pos_s].addr == addr_i);
            hit_o     = hit_o | match_s;
            hit_idx_o = match_s ? pos_s : hit_idx_o;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between core data port and RAM write port.
// Macro STORE_FWD_EN: forward pending stores to loads; otherwise stall hazarding loads.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic          sb_empty,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (!(SB_DEPTH_OK && sb_is_pow2(DEPTH) && (AW == SB_AW) && (DW == SB_DW))) begin : g_cfg_check
        $error("store_buffer: DEPTH must be a power of two >= 2 and AW/DW must match sb_pkg");
    end

    sb_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    sb_state_e        state_q, state_d;

    logic             mem_req_s;
    logic             pop_s;
    logic             push_s;
    logic             full_stall_s;
    logic             hit_s;
    logic [PTR_W-1:0] hit_idx_s;

    sb_match #(.DEPTH(DEPTH)) u_match (
        .entries_i (entries_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .addr_i    (cpu_addr),
        .hit_o     (hit_s),
        .hit_idx_o (hit_idx_s)
    );

    // A full buffer still accepts a store when the head retires in the same cycle.
    assign pop_s        = mem_req_s && mem_ready;
    assign full_stall_s = cpu_we && (count_q == FULL_CNT) && !pop_s;

`ifdef STORE_FWD_EN
    assign cpu_stall = full_stall_s;
    assign cpu_rdata = (cpu_re && hit_s) ? entries_q[hit_idx_s].data : mem_rdata;
`else
    logic unused_hit_idx_s;
    assign unused_hit_idx_s = ^hit_idx_s;
    assign cpu_stall = full_stall_s || (cpu_re && hit_s);
    assign cpu_rdata = mem_rdata;
`endif

    assign push_s    = cpu_we && !cpu_stall;
    assign sb_empty  = (count_q == {CNT_W{1'b0}});
    assign mem_req   = mem_req_s;
    assign mem_addr  = entries_q[head_q].addr;
    assign mem_wdata = entries_q[head_q].data;
    assign mem_raddr = cpu_addr;

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = pop_s  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push_s ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // Drain FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_IDLE:  state_d = (count_d != {CNT_W{1'b0}}) ? SB_DRAIN : SB_IDLE;
            SB_DRAIN: state_d = (pop_s && (count_d == {CNT_W{1'b0}})) ? SB_IDLE : SB_DRAIN;
            default:  state_d = SB_IDLE;
        endcase
    end

    // Drain FSM outputs.
    always_comb begin
        mem_req_s = 1'b0;
        case (state_q)
            SB_IDLE:  mem_req_s = 1'b0;
            SB_DRAIN: mem_req_s = 1'b1;
            default:  mem_req_s = 1'b0;
        endcase
    end

    // State, pointer and count registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= SB_IDLE;
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage, written at tail on an accepted store.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else if (push_s) begin
            entries_q[tail_q] <= '{addr: cpu_addr, data: cpu_wdata};
        end else begin
            entries_q <= entries_q;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: vector table plus scoreboard of expected RAM writes.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        sb_empty;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;

    store_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .sb_empty  (sb_empty),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_mreq;
        logic        e_empty;
        logic [31:0] e_rdata;
    } vec_t;

    ent_t        mq[$];
    int          n_checks;
    int          n_err;
    int          n_writes;
    logic        m_stall;
    logic        s_stall;
    logic        s_mreq;
    logic        s_empty;
    logic [31:0] s_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, check against model, advance model at the edge.
    task automatic cycle(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic ready, input logic [31:0] rdata_in);
        logic        e_mreq;
        logic        e_pop;
        logic        e_stall;
        logic        hit;
        logic [31:0] e_rdata;
        logic [31:0] fwd_data;
        int          sz;
        cpu_we    = we;
        cpu_re    = re;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        mem_ready = ready;
        mem_rdata = rdata_in;
        #1;
        sz       = mq.size();
        e_mreq   = (sz != 0);
        e_pop    = e_mreq && ready;
        hit      = 1'b0;
        fwd_data = 32'h0;
        for (int i = 0; i < sz; i++) begin
            if (mq[i].addr == addr) begin
                hit      = 1'b1;
                fwd_data = mq[i].data;
            end
        end
`ifdef STORE_FWD_EN
        e_stall = we && (sz == DEPTH) && !e_pop;
        e_rdata = (re && hit) ? fwd_data : rdata_in;
`else
        e_stall = (we && (sz == DEPTH) && !e_pop) || (re && hit);
        e_rdata = rdata_in;
`endif
        s_stall = cpu_stall;
        s_mreq  = mem_req;
        s_empty = sb_empty;
        s_rdata = cpu_rdata;
        chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
        chk("mem_req", 32'(mem_req), 32'(e_mreq));
        chk("sb_empty", 32'(sb_empty), 32'(sz == 0));
        chk("mem_raddr", mem_raddr, addr);
        if (re || !hit) begin
            chk("cpu_rdata", cpu_rdata, e_rdata);
        end
        if (e_mreq) begin
            chk("mem_addr", mem_addr, mq[0].addr);
            chk("mem_wdata", mem_wdata, mq[0].data);
        end
        m_stall = e_stall;
        @(posedge clk);
        if (e_pop) begin
            void'(mq.pop_front());
            n_writes++;
        end
        if (we && !e_stall) begin
            mq.push_back('{addr: addr, data: wdata});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (mq.size() != 0 && guard < 20) begin
            cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
            guard++;
        end
        chk("drain_bound", 32'(mq.size()), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        chk("drain_empty", 32'(s_empty), 32'h1);
    endtask

    vec_t tbl[5];
    int   guard;
    int   n0;
    logic rdy;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk       = 1'b0;
        n_checks  = 0;
        n_err     = 0;
        n_writes  = 0;
        m_stall   = 1'b0;
        reset     = 1'b0;
        cpu_we    = 1'b0;
        cpu_re    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;

        tbl[0] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 32'h55};
        tbl[1] = '{1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 32'h55};
        tbl[2] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h55, 1'b0, 1'b1, 1'b0, 32'h55};
        tbl[3] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 32'h55};
        tbl[4] = '{1'b0, 1'b1, 32'h10, 32'h0,        1'b1, 32'h66, 1'b0, 1'b0, 1'b1, 32'h66};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset state, single store and its one-cycle drain.
        for (int v = 0; v < 5; v++) begin
            cycle(tbl[v].we, tbl[v].re, tbl[v].addr, tbl[v].wdata, tbl[v].ready, tbl[v].rdata);
            chk($sformatf("tbl%0d_stall", v), 32'(s_stall), 32'(tbl[v].e_stall));
            chk($sformatf("tbl%0d_mreq", v), 32'(s_mreq), 32'(tbl[v].e_mreq));
            chk($sformatf("tbl%0d_empty", v), 32'(s_empty), 32'(tbl[v].e_empty));
            chk($sformatf("tbl%0d_rdata", v), s_rdata, tbl[v].e_rdata);
        end

        // Fill to DEPTH, stall the fifth store, then accept it on a same-cycle pop.
        n0 = n_writes;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'(i + 1), 1'b0, 32'h0);
        end
        cycle(1'b1, 1'b0, 32'h110, 32'h5, 1'b0, 32'h0);
        chk("full_stall", 32'(s_stall), 32'h1);
        cycle(1'b1, 1'b0, 32'h110, 32'h5, 1'b1, 32'h0);
        chk("full_pop_accept", 32'(s_stall), 32'h0);
        cycle(1'b1, 1'b0, 32'h200, 32'h77, 1'b0, 32'h0);
        chk("still_full", 32'(s_stall), 32'h1);
        drain();
        chk("fill_writes", 32'(n_writes - n0), 32'h5);

        // Two stores to one address, then loads that hit and miss.
        cycle(1'b1, 1'b0, 32'h20, 32'h1, 1'b0, 32'h99);
        cycle(1'b1, 1'b0, 32'h20, 32'h2, 1'b0, 32'h99);
        cycle(1'b0, 1'b1, 32'h24, 32'h0, 1'b0, 32'h99);
        chk("load_miss_rdata", s_rdata, 32'h99);
        chk("load_miss_stall", 32'(s_stall), 32'h0);
        cycle(1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 32'h99);
`ifdef STORE_FWD_EN
        chk("fwd_youngest", s_rdata, 32'h2);
        chk("fwd_no_stall", 32'(s_stall), 32'h0);
        drain();
`else
        chk("hazard_stall", 32'(s_stall), 32'h1);
        guard = 0;
        do begin
            cycle(1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 32'h99);
            guard++;
        end while (m_stall && guard < 20);
        chk("hazard_cycles", 32'(guard), 32'h3);
        chk("hazard_rdata", s_rdata, 32'h99);
        chk("hazard_empty", 32'(s_empty), 32'h1);
`endif

        // Ten stores with mem_ready toggling: pointers wrap twice.
        n0  = n_writes;
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            guard = 0;
            do begin
                cycle(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'hA000_0000 + 32'(i), rdy, 32'h0);
                rdy = !rdy;
                guard++;
            end while (m_stall && guard < 20);
            chk("wrap_accept", 32'(m_stall), 32'h0);
        end
        drain();
        chk("wrap_writes", 32'(n_writes - n0), 32'd10);

        // Reset with three pending entries: all discarded, no further writes.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h400 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0, 32'h0);
        end
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("pre_rst_mreq", 32'(s_mreq), 32'h1);
        cpu_we    = 1'b0;
        mem_ready = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        chk("rst_mreq", 32'(s_mreq), 32'h0);
        chk("rst_empty", 32'(s_empty), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
